// File: rtl/slot_allocator_8.sv
// slot_allocator_8: tracks eight shared slots and grants the lowest free one.
// Allocates at most one slot and reclaims at most one slot per cycle.
//
// Ports:
//   clk          : clock; all state changes on the rising edge
//   rst          : synchronous active-high reset
//   alloc_req    : request one slot this cycle
//   alloc_gnt    : registered; high the cycle after a successful allocation
//   alloc_idx    : registered; granted index 0..7, or 8 when there is no grant
//   free_vld     : return the slot given by free_idx this cycle
//   free_idx     : index of the slot being returned
//   busy         : registered occupancy vector; bit i set means slot i is in use
//   free_cnt     : registered number of free slots, 0..8
//   full         : registered; every slot is busy
//   empty        : registered; no slot is busy
//   err_dbl_free : sticky flag; a slot that was not busy was freed
module slot_allocator_8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       alloc_req,
    output logic       alloc_gnt,
    output logic [3:0] alloc_idx,
    input  logic       free_vld,
    input  logic [2:0] free_idx,
    output logic [7:0] busy,
    output logic [3:0] free_cnt,
    output logic       full,
    output logic       empty,
    output logic       err_dbl_free
);

    logic [3:0] first_free;
    logic       alloc_do;
    logic       free_do;
    logic       dbl_free;
    logic [7:0] busy_nxt;
    logic [3:0] cnt_nxt;

    // The search runs from the top index down, so the lowest free slot is
    // the one that survives. It looks only at the registered busy vector;
    // a slot freed in this same cycle is not visible to it yet.
    always_comb begin
        first_free = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (!busy[i]) begin
                first_free = 4'(i);
            end
        end
    end

    assign alloc_do = alloc_req && !first_free[3];

    // Freeing the slot that is being allocated in the same cycle counts as
    // a double free. That slot is free in the registered vector, so the
    // double-free test below covers this case.
    assign free_do  = free_vld && busy[free_idx];
    assign dbl_free = free_vld && !busy[free_idx];

    // An allocation and a valid free always touch different bits.
    always_comb begin
        busy_nxt = busy;
        if (alloc_do) begin
            busy_nxt[first_free[2:0]] = 1'b1;
        end
        if (free_do) begin
            busy_nxt[free_idx] = 1'b0;
        end
    end

    always_comb begin
        cnt_nxt = free_cnt;
        if (alloc_do && !free_do) begin
            cnt_nxt = free_cnt - 4'd1;
        end else if (free_do && !alloc_do) begin
            cnt_nxt = free_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= 8'h00;
            free_cnt     <= 4'd8;
            alloc_gnt    <= 1'b0;
            alloc_idx    <= 4'd8;
            full         <= 1'b0;
            empty        <= 1'b1;
            err_dbl_free <= 1'b0;
        end else begin
            busy      <= busy_nxt;
            free_cnt  <= cnt_nxt;
            alloc_gnt <= alloc_do;
            alloc_idx <= alloc_do ? first_free : 4'd8;
            full      <= &busy_nxt;
            empty     <= ~|busy_nxt;
            if (dbl_free) begin
                err_dbl_free <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_slot_allocator_8.sv
// tb_slot_allocator_8: self-checking bench for slot_allocator_8.
// Runs directed scenarios, then randomized traffic checked against a slot-array model.
module tb_slot_allocator_8;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [3:0] alloc_idx;
    logic       free_vld;
    logic [2:0] free_idx;
    logic [7:0] busy;
    logic [3:0] free_cnt;
    logic       full;
    logic       empty;
    logic       err_dbl_free;

    int checks = 0;
    int errors = 0;

    // Model state: one flag per slot, plus the last grant and the sticky error.
    bit m_slot[8];
    bit m_gnt;
    int m_idx;
    bit m_err;

    slot_allocator_8 dut (
        .clk(clk),
        .rst(rst),
        .alloc_req(alloc_req),
        .alloc_gnt(alloc_gnt),
        .alloc_idx(alloc_idx),
        .free_vld(free_vld),
        .free_idx(free_idx),
        .busy(busy),
        .free_cnt(free_cnt),
        .full(full),
        .empty(empty),
        .err_dbl_free(err_dbl_free)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_free_count();
        int n = 0;
        for (int i = 0; i < 8; i++) if (!m_slot[i]) n++;
        return n;
    endfunction

    function automatic logic [7:0] m_busy_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_slot[i];
        return v;
    endfunction

    task automatic model_step(input bit r, input bit a, input bit fv,
                              input int fi);
        int lowest;
        bit ok_free;
        if (r) begin
            foreach (m_slot[i]) m_slot[i] = 0;
            m_gnt = 0;
            m_idx = 8;
            m_err = 0;
            return;
        end
        lowest = 8;
        for (int i = 7; i >= 0; i--) if (!m_slot[i]) lowest = i;
        ok_free = fv && m_slot[fi];
        if (fv && !m_slot[fi]) m_err = 1;
        if (a && lowest < 8) begin
            m_slot[lowest] = 1;
            m_gnt = 1;
            m_idx = lowest;
        end else begin
            m_gnt = 0;
            m_idx = 8;
        end
        if (ok_free) m_slot[fi] = 0;
    endtask

    task automatic cyc(input bit r, input bit a, input bit fv, input int fi);
        rst       = r;
        alloc_req = a;
        free_vld  = fv;
        free_idx  = 3'(fi);
        @(posedge clk);
        model_step(r, a, fv, fi);
        #1;
        chk("alloc_gnt", 32'(alloc_gnt), 32'(m_gnt));
        chk("alloc_idx", 32'(alloc_idx), 32'(m_idx));
        chk("busy", 32'(busy), 32'(m_busy_vec()));
        chk("free_cnt", 32'(free_cnt), 32'(m_free_count()));
        chk("full", 32'(full), 32'(m_free_count() == 0));
        chk("empty", 32'(empty), 32'(m_free_count() == 8));
        chk("err_dbl_free", 32'(err_dbl_free), 32'(m_err));
        rst       = 1'b0;
        alloc_req = 1'b0;
        free_vld  = 1'b0;
    endtask

    initial begin
        int fi;
        bit found;
        rst       = 1'b1;
        alloc_req = 1'b0;
        free_vld  = 1'b0;
        free_idx  = 3'd0;

        // Reset state
        cyc(1, 0, 0, 0);
        chk("rst_busy", 32'(busy), 32'h00);
        chk("rst_cnt", 32'(free_cnt), 32'd8);
        chk("rst_idx", 32'(alloc_idx), 32'd8);
        chk("rst_empty", 32'(empty), 32'd1);

        // Nine requests: grants 0..7, then no grant
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 0);
            chk("fill_idx", 32'(alloc_idx), 32'(i));
            chk("fill_cnt", 32'(free_cnt), 32'(7 - i));
        end
        chk("fill_full", 32'(full), 32'd1);
        cyc(0, 1, 0, 0);
        chk("ninth_gnt", 32'(alloc_gnt), 32'd0);
        chk("ninth_idx", 32'(alloc_idx), 32'd8);

        // Free 3 from full, then reallocate it
        cyc(0, 0, 1, 3);
        chk("f3_busy", 32'(busy), 32'hF7);
        chk("f3_cnt", 32'(free_cnt), 32'd1);
        chk("f3_full", 32'(full), 32'd0);
        cyc(0, 1, 0, 0);
        chk("re3_idx", 32'(alloc_idx), 32'd3);
        chk("re3_busy", 32'(busy), 32'hFF);

        // From 3F: alloc and free 5 together; the allocation must get 6
        cyc(0, 0, 1, 7);
        cyc(0, 0, 1, 6);
        chk("3f_busy", 32'(busy), 32'h3F);
        cyc(0, 1, 1, 5);
        chk("sim_idx", 32'(alloc_idx), 32'd6);
        chk("sim_busy", 32'(busy), 32'h5F);
        chk("sim_cnt", 32'(free_cnt), 32'd2);

        // Double free with busy=01
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 2);
        chk("dbl_err", 32'(err_dbl_free), 32'd1);
        chk("dbl_busy", 32'(busy), 32'h01);
        chk("dbl_cnt", 32'(free_cnt), 32'd7);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);
        chk("dbl_hold", 32'(err_dbl_free), 32'd1);

        // Full: alloc plus free 0 gives no grant; slot 0 is granted next cycle
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        chk("fullsim_gnt", 32'(alloc_gnt), 32'd0);
        chk("fullsim_idx", 32'(alloc_idx), 32'd8);
        chk("fullsim_busy", 32'(busy), 32'hFE);
        cyc(0, 1, 0, 0);
        chk("fullsim_re", 32'(alloc_idx), 32'd0);

        // A5 with the error flag set, then reset asserted together with a request
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 3);
        cyc(0, 0, 1, 4);
        cyc(0, 0, 1, 6);
        cyc(0, 0, 1, 1);
        chk("a5_busy", 32'(busy), 32'hA5);
        chk("a5_err", 32'(err_dbl_free), 32'd1);
        cyc(1, 1, 0, 0);
        chk("rr_busy", 32'(busy), 32'h00);
        chk("rr_gnt", 32'(alloc_gnt), 32'd0);
        chk("rr_err", 32'(err_dbl_free), 32'd0);

        // Randomized traffic; frees usually target a busy slot
        for (int n = 0; n < 3000; n++) begin
            fi = $urandom_range(7, 0);
            if ($urandom_range(3, 0) != 0) begin
                found = 0;
                for (int k = 0; k < 8; k++) begin
                    if (!found && m_slot[(fi + k) % 8]) begin
                        fi = (fi + k) % 8;
                        found = 1;
                    end
                end
            end
            cyc($urandom_range(99, 0) == 0, $urandom_range(2, 0) != 0,
                $urandom_range(1, 0) == 1, fi);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
